// File: rtl/knn_select_engine_if.sv
// Handshake and result bundle for the KNN select engine.
// The master side sets the test point, streams points and reads results.
interface knn_select_engine_if #(
  parameter int DATA_W      = 32,
  parameter int LABEL       = 8,
  parameter int N_NEIGHBOUR = 4
);
  localparam int DIST_W = DATA_W + 1;
  localparam int CNT_W  = $clog2(N_NEIGHBOUR + 1);

  logic                         start;
  logic [DATA_W-1:0]            A;
  logic [DATA_W-1:0]            B;
  logic [LABEL-1:0]             label;
  logic                         pt_valid;
  logic                         pt_last;
  logic [N_NEIGHBOUR*LABEL-1:0] nbr_labels;
  logic [DIST_W-1:0]            nbr_dist0;
  logic [CNT_W-1:0]             count;
  logic                         busy;
  logic                         valid;

  modport master (
    output start, A, B, label, pt_valid, pt_last,
    input  nbr_labels, nbr_dist0, count, busy, valid
  );

  modport slave (
    input  start, A, B, label, pt_valid, pt_last,
    output nbr_labels, nbr_dist0, count, busy, valid
  );
endinterface

// File: rtl/knn_select_engine.sv
// K-nearest-neighbour selector: squared distance stage followed by
// a sorted insertion stage into a K-entry slot array.
module knn_select_engine #(
  parameter int DATA_W      = 32,
  parameter int LABEL       = 8,
  parameter int N_NEIGHBOUR = 4,
  parameter int DIST_W      = DATA_W + 1
) (
  input logic                 clk,
  input logic                 rst,
  knn_select_engine_if.slave  bus
);
  localparam int HW    = DATA_W / 2;
  localparam int K     = N_NEIGHBOUR;
  localparam int CNT_W = $clog2(K + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DIST_W-1:0] r_dist [K];
  logic [LABEL-1:0]  r_lbl  [K];
  logic [CNT_W-1:0]  r_count;
  logic              r_busy;
  logic              r_valid;

  logic              r_s1_vld;
  logic [DIST_W-1:0] r_s1_dist;
  logic [LABEL-1:0]  r_s1_lbl;

  logic              w_accept;
  logic [HW-1:0]     w_ax, w_ay, w_bx, w_by;
  logic [HW-1:0]     w_dx, w_dy;
  logic [DIST_W-1:0] w_dist;
  logic [K-1:0]      w_lt;
  logic              w_ins;

  assign w_accept = (r_state == S_LOAD) && bus.pt_valid;

  assign w_ax = bus.A[DATA_W-1:HW];
  assign w_ay = bus.A[HW-1:0];
  assign w_bx = bus.B[DATA_W-1:HW];
  assign w_by = bus.B[HW-1:0];

  assign w_dx = (w_ax >= w_bx) ? w_ax - w_bx : w_bx - w_ax;
  assign w_dy = (w_ay >= w_by) ? w_ay - w_by : w_by - w_ay;

  // 2*HW-bit squares summed into DIST_W bits cannot overflow
  assign w_dist = DIST_W'(w_dx) * DIST_W'(w_dx)
                + DIST_W'(w_dy) * DIST_W'(w_dy);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  w_next = S_IDLE;
      S_LOAD:  if (w_accept && bus.pt_last) w_next = S_DRAIN;
      S_DRAIN: w_next = S_DONE;
      S_DONE:  w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
    if (bus.start) w_next = S_LOAD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == S_LOAD) || (w_next == S_DRAIN);
      r_valid <= (w_next == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.start) begin
      r_s1_vld  <= 1'b0;
      r_s1_dist <= '0;
      r_s1_lbl  <= '0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_dist <= w_dist;
        r_s1_lbl  <= bus.label;
      end
    end
  end

  // strict compare keeps earlier equal-distance points ahead
  always_comb begin
    w_lt = '0;
    for (int i = 0; i < K; i++) w_lt[i] = r_s1_dist < r_dist[i];
    w_ins = r_s1_vld && (|w_lt);
  end

  always_ff @(posedge clk) begin
    if (rst || bus.start) begin
      for (int i = 0; i < K; i++) begin
        r_dist[i] <= '1;
        r_lbl[i]  <= '0;
      end
      r_count <= '0;
    end else if (w_ins) begin
      if (w_lt[0]) begin
        r_dist[0] <= r_s1_dist;
        r_lbl[0]  <= r_s1_lbl;
      end
      for (int i = 1; i < K; i++) begin
        if (w_lt[i-1]) begin
          r_dist[i] <= r_dist[i-1];
          r_lbl[i]  <= r_lbl[i-1];
        end else if (w_lt[i]) begin
          r_dist[i] <= r_s1_dist;
          r_lbl[i]  <= r_s1_lbl;
        end
      end
      if (r_count < CNT_W'(K)) r_count <= r_count + 1'b1;
    end
  end

  always_comb begin
    bus.nbr_labels = '0;
    for (int i = 0; i < K; i++)
      bus.nbr_labels[i*LABEL +: LABEL] = r_lbl[i];
  end

  assign bus.nbr_dist0 = r_dist[0];
  assign bus.count     = r_count;
  assign bus.busy      = r_busy;
  assign bus.valid     = r_valid;
endmodule

// File: tb/tb_knn_select_engine.sv
// Directed bench for knn_select_engine with hand-computed results.
// Inputs change 1ns after each rising edge; outputs are checked there.
module tb_knn_select_engine;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  knn_select_engine_if #(.DATA_W(32), .LABEL(8), .N_NEIGHBOUR(4)) bus ();

  knn_select_engine #(
    .DATA_W(32), .LABEL(8), .N_NEIGHBOUR(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    bus.start    = 1'b0;
    bus.pt_valid = 1'b0;
    bus.pt_last  = 1'b0;
    bus.B        = '0;
    bus.label    = '0;
  endtask

  task automatic go(input logic [15:0] ax, input logic [15:0] ay);
    bus.A     = {ax, ay};
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic pt(input logic [15:0] x, input logic [15:0] y,
                    input logic [7:0] l, input logic last);
    bus.B        = {x, y};
    bus.label    = l;
    bus.pt_valid = 1'b1;
    bus.pt_last  = last;
    step();
    idle_in();
  endtask

  initial begin
    idle_in();
    bus.A = '0;
    rst   = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_valid", 64'(bus.valid), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_count", 64'(bus.count), 64'h0);
    chk("rst_labels", 64'(bus.nbr_labels), 64'h0);
    chk("rst_dist0", 64'(bus.nbr_dist0), 64'h1_FFFF_FFFF);

    pt(16'd0, 16'd0, 8'd99, 1'b1);
    step();
    chk("idle_count", 64'(bus.count), 64'h0);
    chk("idle_labels", 64'(bus.nbr_labels), 64'h0);
    chk("idle_busy", 64'(bus.busy), 64'h0);

    go(16'd0, 16'd0);
    chk("load_busy", 64'(bus.busy), 64'h1);
    bus.pt_valid = 1'b1;
    bus.B = {16'd3, 16'd4};  bus.label = 8'd1; step();
    bus.B = {16'd1, 16'd1};  bus.label = 8'd2; step();
    bus.B = {16'd10, 16'd0}; bus.label = 8'd3; step();
    bus.B = {16'd0, 16'd2};  bus.label = 8'd4; step();
    bus.B = {16'd5, 16'd5};  bus.label = 8'd5; bus.pt_last = 1'b1;
    step();
    idle_in();
    chk("drain_valid", 64'(bus.valid), 64'h0);
    chk("drain_busy", 64'(bus.busy), 64'h1);
    step();
    chk("sort_valid", 64'(bus.valid), 64'h1);
    chk("sort_busy", 64'(bus.busy), 64'h0);
    chk("sort_labels", 64'(bus.nbr_labels), 64'h0501_0402);
    chk("sort_dist0", 64'(bus.nbr_dist0), 64'h2);
    chk("sort_count", 64'(bus.count), 64'h4);

    pt(16'd0, 16'd0, 8'd77, 1'b1);
    step();
    chk("done_valid", 64'(bus.valid), 64'h1);
    chk("done_labels", 64'(bus.nbr_labels), 64'h0501_0402);
    chk("done_dist0", 64'(bus.nbr_dist0), 64'h2);

    go(16'd100, 16'd100);
    chk("tie_clr_count", 64'(bus.count), 64'h0);
    pt(16'd103, 16'd104, 8'd7, 1'b0);
    pt(16'd96, 16'd97, 8'd9, 1'b1);
    step();
    chk("tie_valid", 64'(bus.valid), 64'h1);
    chk("tie_labels", 64'(bus.nbr_labels), 64'h0000_0907);
    chk("tie_dist0", 64'(bus.nbr_dist0), 64'd25);
    chk("tie_count", 64'(bus.count), 64'h2);

    go(16'd0, 16'd0);
    pt(16'd1, 16'd0, 8'd11, 1'b0);
    pt(16'd0, 16'd1, 8'd12, 1'b0);
    go(16'd0, 16'd0);
    chk("rs_count", 64'(bus.count), 64'h0);
    chk("rs_labels", 64'(bus.nbr_labels), 64'h0);
    chk("rs_busy", 64'(bus.busy), 64'h1);
    step();
    chk("rs_flight", 64'(bus.count), 64'h0);
    pt(16'd2, 16'd2, 8'd20, 1'b0);
    pt(16'd7, 16'd0, 8'd21, 1'b1);
    step();
    chk("rs_valid", 64'(bus.valid), 64'h1);
    chk("rs_final", 64'(bus.nbr_labels), 64'h0000_1514);
    chk("rs_dist0", 64'(bus.nbr_dist0), 64'd8);
    chk("rs_fcount", 64'(bus.count), 64'h2);

    go(16'd0, 16'd0);
    pt(16'hFFFF, 16'hFFFF, 8'd33, 1'b1);
    step();
    chk("ext_valid", 64'(bus.valid), 64'h1);
    chk("ext_dist0", 64'(bus.nbr_dist0), 64'h1_FFFC_0002);
    chk("ext_labels", 64'(bus.nbr_labels), 64'h0000_0021);
    chk("ext_count", 64'(bus.count), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
